// File: rtl/fft_pkg.sv
// Shared types and limits for the FFT sequencing controller.
package fft_pkg;

    localparam int MAX_SAMPLES = 2048;
    localparam int STAGE_WIDTH = 4;
    localparam int MAX_LOG2    = $clog2(MAX_SAMPLES);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CHECK,
        S_GUARD,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/fft_log2.sv
// Combinational transform-length check: flags a power-of-two N in 2..MAX_SAMPLES
// and returns log2(N) as the number of butterfly stages.
module fft_log2
    import fft_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int STG_W        = 4
) (
    input  logic [SAMPLE_WIDTH-1:0] samples_i,
    output logic                    valid_o,
    output logic [STG_W-1:0]        stages_o
);

    // Exactly one bit may match, so the loop resolves to a single hit at most.
    always_comb begin
        valid_o  = 1'b0;
        stages_o = '0;
        for (int i = 1; i < SAMPLE_WIDTH; i++) begin
            if (i <= MAX_LOG2 && samples_i == (SAMPLE_WIDTH'(1) << i)) begin
                valid_o  = 1'b1;
                stages_o = STG_W'(i);
            end
        end
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Stage sequencer for the FFT core: hands RAM between AXI and the butterfly
// engine and steps through log2(N) stages. FFT_SEQ_WATCHDOG_EN adds a per-stage timeout.
module fft_seq_ctrl #(
    parameter int SAMPLE_WIDTH   = 12,
    parameter int STAGE_WIDTH    = fft_pkg::STAGE_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_DATA_LOADED,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLES_NUMBER,
    input  logic                    i_STAGE_DONE,
    input  logic                    i_RESULT_READ,
    output logic                    o_MODE,
    output logic                    o_STAGE_START,
    output logic [STAGE_WIDTH-1:0]  o_STAGE_IDX,
    output logic                    o_CALC_END,
    output logic                    o_BUSY,
`ifdef FFT_SEQ_WATCHDOG_EN
    output logic                    o_TIMEOUT,
`endif
    output logic                    o_ERR
);
    import fft_pkg::*;

    state_e                 state_q;
    logic                   mode_q, start_q, calc_end_q, busy_q, err_q;
    logic [STAGE_WIDTH-1:0] idx_q, stages_q;
    logic                   n_valid;
    logic [STAGE_WIDTH-1:0] n_stages;

    fft_log2 #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .STG_W        (STAGE_WIDTH)
    ) u_log2 (
        .samples_i (i_SAMPLES_NUMBER),
        .valid_o   (n_valid),
        .stages_o  (n_stages)
    );

`ifdef FFT_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            timeout_q;
    assign o_TIMEOUT = timeout_q;
`else
    logic [31:0] wd_unused;
    assign wd_unused = 32'(TIMEOUT_CYCLES);
`endif

    // Outputs are registered from the current state, so they trail the state by one edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_LOAD;
            mode_q     <= 1'b1;
            start_q    <= 1'b0;
            idx_q      <= '0;
            stages_q   <= '0;
            calc_end_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef FFT_SEQ_WATCHDOG_EN
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    mode_q     <= 1'b1;
                    start_q    <= 1'b0;
                    calc_end_q <= 1'b0;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b0;
                    if (i_DATA_LOADED) state_q <= S_CHECK;
                end
                S_CHECK: begin
                    mode_q     <= 1'b1;
                    busy_q     <= 1'b1;
                    err_q      <= 1'b0;
                    calc_end_q <= 1'b0;
                    if (n_valid) begin
                        stages_q <= n_stages;
                        state_q  <= S_GUARD;
                    end else begin
                        state_q  <= S_ERR;
                    end
                end
                S_GUARD: begin
                    mode_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_START;
                end
                S_START: begin
                    mode_q  <= 1'b0;
                    start_q <= 1'b1;
`ifdef FFT_SEQ_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    mode_q  <= 1'b0;
                    start_q <= 1'b0;
                    if (i_STAGE_DONE) begin
                        if (idx_q == stages_q - STAGE_WIDTH'(1)) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + STAGE_WIDTH'(1);
                            state_q <= S_START;
                        end
                    end
`ifdef FFT_SEQ_WATCHDOG_EN
                    else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_ERR;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    mode_q     <= 1'b1;
                    start_q    <= 1'b0;
                    calc_end_q <= 1'b1;
                    busy_q     <= 1'b0;
                    // A load pulse arriving with the read pulse is deliberately dropped.
                    if (i_RESULT_READ) state_q <= S_LOAD;
                end
                S_ERR: begin
                    mode_q     <= 1'b1;
                    start_q    <= 1'b0;
                    calc_end_q <= 1'b0;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b1;
                    if (i_DATA_LOADED) begin
`ifdef FFT_SEQ_WATCHDOG_EN
                        timeout_q <= 1'b0;
`endif
                        state_q <= S_CHECK;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign o_MODE        = mode_q;
    assign o_STAGE_START = start_q;
    assign o_STAGE_IDX   = idx_q;
    assign o_CALC_END    = calc_end_q;
    assign o_BUSY        = busy_q;
    assign o_ERR         = err_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: a per-cycle vector table for a full N=8 run
// plus hand-written sequences for error, reset, collision and stray-pulse cases.
module tb_fft_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        loaded = 1'b0, sdone = 1'b0, rread = 1'b0;
    logic [11:0] nsamp = 12'd8;
    logic        mode, start, calc_end, busy, err;
    logic [3:0]  idx;
`ifdef FFT_SEQ_WATCHDOG_EN
    logic        tmo;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    fft_seq_ctrl #(
        .SAMPLE_WIDTH   (12),
        .STAGE_WIDTH    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_DATA_LOADED    (loaded),
        .i_SAMPLES_NUMBER (nsamp),
        .i_STAGE_DONE     (sdone),
        .i_RESULT_READ    (rread),
        .o_MODE           (mode),
        .o_STAGE_START    (start),
        .o_STAGE_IDX      (idx),
        .o_CALC_END       (calc_end),
        .o_BUSY           (busy),
`ifdef FFT_SEQ_WATCHDOG_EN
        .o_TIMEOUT        (tmo),
`endif
        .o_ERR            (err)
    );

    typedef struct {
        logic       l, d, r;
        logic       m, s;
        logic [3:0] i;
        logic       c, b, e;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (start) n_starts++;
    endtask

    task automatic load(input logic [11:0] n);
        nsamp  = n;
        loaded = 1'b1;
        step();
        loaded = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (!start && k < 12) begin
            step();
            k++;
        end
        chk({name, "_start_seen"}, {31'd0, start}, 32'd1);
    endtask

    // After a load: each stage gets its done pulse two cycles after its start.
    task automatic run_to_done(input string name, input int nst);
        for (int s = 0; s < nst; s++) begin
            wait_start(name);
            chk({name, "_idx"}, {28'd0, idx}, 32'(s));
            step();
            sdone = 1'b1;
            step();
            sdone = 1'b0;
        end
        step();
        chk({name, "_calc_end"}, {30'd0, calc_end, mode}, 32'b11);
    endtask

    task automatic add(input logic l, d, r, m, s, input logic [3:0] i, input logic c, b, e);
        vec_t v;
        v.l = l; v.d = d; v.r = r; v.m = m; v.s = s; v.i = i; v.c = c; v.b = b; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        //   l  d  r   m  s  idx   c  b  e
        add(1, 0, 0,  1, 0, 4'd0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 4'd0, 0, 1, 0);
        add(0, 0, 0,  0, 0, 4'd0, 0, 1, 0);
        add(0, 0, 0,  0, 1, 4'd0, 0, 1, 0);
        add(0, 0, 0,  0, 0, 4'd0, 0, 1, 0);
        add(0, 1, 0,  0, 0, 4'd1, 0, 1, 0);
        add(0, 0, 0,  0, 1, 4'd1, 0, 1, 0);
        add(0, 0, 0,  0, 0, 4'd1, 0, 1, 0);
        add(0, 1, 0,  0, 0, 4'd2, 0, 1, 0);
        add(0, 0, 0,  0, 1, 4'd2, 0, 1, 0);
        add(0, 0, 0,  0, 0, 4'd2, 0, 1, 0);
        add(0, 1, 0,  0, 0, 4'd2, 0, 1, 0);
        add(0, 0, 0,  1, 0, 4'd2, 1, 0, 0);
        add(0, 0, 0,  1, 0, 4'd2, 1, 0, 0);
        add(0, 0, 1,  1, 0, 4'd2, 1, 0, 0);
        add(0, 0, 0,  1, 0, 4'd2, 0, 0, 0);

        #12;
        chk("reset_outputs", {23'd0, mode, start, idx, calc_end, busy, err}, {23'd0, 9'b1_0_0000_000});
        rst = 1'b0;
        step();

        // Full N=8 run, one table row per clock edge.
        nsamp = 12'd8;
        foreach (vecs[k]) begin
            loaded = vecs[k].l; sdone = vecs[k].d; rread = vecs[k].r;
            step();
            chk($sformatf("vec%0d", k), {23'd0, mode, start, idx, calc_end, busy, err},
                {23'd0, vecs[k].m, vecs[k].s, vecs[k].i, vecs[k].c, vecs[k].b, vecs[k].e});
        end
        loaded = 1'b0; sdone = 1'b0; rread = 1'b0;
        chk("n8_start_count", 32'(n_starts), 32'd3);

        // Invalid N lands in error; a valid reload recovers.
        n_starts = 0;
        load(12'd12);
        step(); step();
        chk("n12_err", {30'd0, err, mode}, 32'b11);
        repeat (4) step();
        chk("n12_no_start", 32'(n_starts), 32'd0);
        load(12'd4);
        run_to_done("n4", 2);
        chk("n4_err_clear", {31'd0, err}, 32'd0);
        chk("n4_start_count", 32'(n_starts), 32'd2);
        rread = 1'b1; step(); rread = 1'b0; step();

        // Reset in the wait of stage 1 with N=16.
        n_starts = 0;
        load(12'd16);
        wait_start("r16a");
        step(); sdone = 1'b1; step(); sdone = 1'b0;
        wait_start("r16b");
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {26'd0, mode, start, idx}, {26'd0, 1'b1, 1'b0, 4'd0});
        #3 rst = 1'b0;
        n_starts = 0;
        repeat (6) step();
        chk("rst_no_start", 32'(n_starts), 32'd0);
        load(12'd8);
        wait_start("rst_reload");
        chk("rst_reload_idx", {28'd0, idx}, 32'd0);
        // Finish this run so the DUT is back in DONE.
        step(); sdone = 1'b1; step(); sdone = 1'b0;
        wait_start("rst_s1"); step(); sdone = 1'b1; step(); sdone = 1'b0;
        wait_start("rst_s2"); step(); sdone = 1'b1; step(); sdone = 1'b0;
        step();
        chk("rst_run_done", {31'd0, calc_end}, 32'd1);

        // Read and load together in DONE: read wins, load dropped.
        n_starts = 0;
        rread = 1'b1; loaded = 1'b1;
        step();
        rread = 1'b0; loaded = 1'b0;
        step();
        chk("collide_load_state", {29'd0, calc_end, busy, mode}, 32'b001);
        repeat (5) step();
        chk("collide_no_start", {31'd0, busy}, 32'd0);
        chk("collide_no_start_cnt", 32'(n_starts), 32'd0);
        load(12'd2);
        run_to_done("collide_rerun", 1);
        rread = 1'b1; step(); rread = 1'b0; step();

        // Stray done pulses in GUARD and START with N=2.
        n_starts = 0;
        load(12'd2);
        step();
        sdone = 1'b1;
        step(); step();
        sdone = 1'b0;
        chk("stray_start", {27'd0, start, idx}, {27'd0, 1'b1, 4'd0});
        step(); step(); step();
        chk("stray_still_wait", {30'd0, calc_end, busy}, 32'b01);
        sdone = 1'b1; step(); sdone = 1'b0;
        step();
        chk("stray_done", {31'd0, calc_end}, 32'd1);
        chk("stray_start_count", 32'(n_starts), 32'd1);
        rread = 1'b1; step(); rread = 1'b0; step();

`ifdef FFT_SEQ_WATCHDOG_EN
        load(12'd4);
        wait_start("wd");
        repeat (15) step();
        chk("wd_not_yet", {31'd0, tmo}, 32'd0);
        step();
        chk("wd_timeout", {31'd0, tmo}, 32'd1);
        step();
        chk("wd_err", {30'd0, err, tmo}, 32'b11);
        load(12'd4);
        chk("wd_clear", {31'd0, tmo}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12: width of the sample-count input.
REQ-002 SHALL have parameter STAGE_WIDTH, default 4: width of the stage index.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit per stage (only with REQ-025).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_DATA_LOADED, input, 1 bit: one-cycle pulse from the AXI bridge when the sample load is complete.
REQ-007 SHALL have port i_SAMPLES_NUMBER, input, SAMPLE_WIDTH bits: N, the transform length.
REQ-008 SHALL have port i_STAGE_DONE, input, 1 bit: one-cycle pulse from the butterfly engine at the end of a stage.
REQ-009 SHALL have port i_RESULT_READ, input, 1 bit: one-cycle pulse from the bridge after the last result is read.
REQ-010 SHALL have port o_MODE, output, 1 bit: RAM owner; 1 = AXI, 0 = circuit; drives the RAM mode input.
REQ-011 SHALL have port o_STAGE_START, output, 1 bit: one-cycle pulse that starts a stage.
REQ-012 SHALL have port o_STAGE_IDX, output, STAGE_WIDTH bits: index of the current stage.
REQ-013 SHALL have port o_CALC_END, output, 1 bit: level; results are ready for AXI readback.
REQ-014 SHALL have port o_BUSY, output, 1 bit: high from S_CHECK through the last stage.
REQ-015 SHALL have port o_ERR, output, 1 bit: high while in S_ERR.

Function
REQ-016 SHALL implement these FSM states: S_LOAD, S_CHECK, S_GUARD, S_START, S_WAIT, S_DONE, S_ERR.
REQ-017 SHALL handle S_LOAD as follows: o_MODE = 1; i_DATA_LOADED goes to S_CHECK; all other inputs are ignored.
REQ-018 SHALL handle S_CHECK as follows: N valid (power of two, 2..2048) goes to S_GUARD with stage count log2(N) latched; otherwise goes to S_ERR.
REQ-019 SHALL handle S_GUARD as follows: o_MODE = 0 for one idle cycle (RAM ownership handover), o_STAGE_IDX = 0, then go to S_START.
REQ-020 SHALL handle S_START as follows: o_STAGE_START = 1 for exactly one cycle, then go to S_WAIT.
REQ-021 SHALL handle S_WAIT as follows: i_STAGE_DONE is sampled only here; on the last stage go to S_DONE, otherwise increment o_STAGE_IDX and go to S_START.
REQ-022 SHALL handle S_DONE as follows: o_MODE = 1, o_CALC_END = 1; i_RESULT_READ goes to S_LOAD.
REQ-023 SHALL handle S_ERR as follows: o_MODE = 1, o_ERR = 1; i_DATA_LOADED goes to S_CHECK, re-validating N.
REQ-024 SHALL meet this timing and these boundary rules:
- i_DATA_LOADED sampled at edge t gives o_MODE = 0 after edge t+2 and o_STAGE_START high after edge t+3.
- i_DATA_LOADED and i_RESULT_READ high together in S_DONE: i_RESULT_READ wins; the load pulse is dropped.
- i_STAGE_DONE outside S_WAIT is ignored.
- N is sampled only in S_CHECK; later changes have no effect.

Configuration
REQ-025 SHALL provide the macro FFT_SEQ_WATCHDOG_EN.
- Defined: adds output port o_TIMEOUT (1 bit) and a cycle counter that clears on entry to S_WAIT. If TIMEOUT_CYCLES elapse without i_STAGE_DONE, the FSM goes to S_ERR and sets o_TIMEOUT. o_TIMEOUT clears when S_ERR is exited.
- Not defined: the port and counter are absent, and S_WAIT waits indefinitely.

Reset
REQ-026 SHALL, on i_rst, asynchronously force: state = S_LOAD, o_MODE = 1, o_STAGE_START = 0, o_STAGE_IDX = 0, o_CALC_END = 0, o_BUSY = 0, o_ERR = 0, o_TIMEOUT = 0, latched stage count = 0.
REQ-027 SHALL, on reset mid-calculation, return RAM ownership to AXI immediately and emit no further stage pulses.

Structure
REQ-028 SHALL place the state enum, MAX_SAMPLES = 2048 and STAGE_WIDTH in the shared package fft_pkg.
REQ-029 SHALL compute the validity check and log2 in the combinational sub-module fft_log2, which outputs a valid flag and the stage count.

Verification
REQ-030 SHALL verify: N = 8, i_DATA_LOADED pulse, i_STAGE_DONE pulsed 2 cycles after each start -> 3 start pulses with o_STAGE_IDX 0, 1, 2; o_CALC_END = 1 and o_MODE = 1 afterwards.
REQ-031 SHALL verify: N = 12, i_DATA_LOADED -> o_ERR = 1 and no start pulse; then N = 4 with i_DATA_LOADED -> 2 stages run and o_ERR = 0.
REQ-032 SHALL verify: i_rst asserted in S_WAIT of stage 1 with N = 16 -> o_MODE = 1 and o_STAGE_IDX = 0 in the same cycle; no start pulse until a new i_DATA_LOADED.
REQ-033 SHALL verify: in S_DONE, i_RESULT_READ and i_DATA_LOADED asserted in the same cycle -> S_LOAD entered; a following i_DATA_LOADED starts a new run.
REQ-034 SHALL verify: a stray i_STAGE_DONE in S_GUARD or S_START, with N = 2 -> ignored; exactly one stage completes.
REQ-035 SHALL verify: with FFT_SEQ_WATCHDOG_EN defined and TIMEOUT_CYCLES = 16, i_STAGE_DONE withheld -> o_TIMEOUT = 1 and o_ERR = 1 after 16 cycles in S_WAIT.
